// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK per stage, carry rippling
// between stage registers, valid/ready stream with global stall.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SDIV = (STAGES > 0) ? STAGES : 1;
    localparam int C    = (WIDTH / SDIV > 0) ? WIDTH / SDIV : 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH
        || (WIDTH % SDIV) != 0) begin : g_bad_params
        $error("pipelined_addsub: illegal WIDTH/STAGES");
    end

    // Stage registers: operands travel whole-width so upper chunks
    // arrive skewed and finished lower chunks travel deskewed.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;

    // Per-stage inputs and next-state values
    logic [WIDTH-1:0]  a_s [STAGES];
    logic [WIDTH-1:0]  b_s [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [WIDTH-1:0]  r_n [STAGES];
    logic [C:0]        part [STAGES];
    logic [STAGES-1:0] c_s;
    logic [STAGES-1:0] c_n;
    logic [STAGES-1:0] v_s;
    logic              ovf_n;
    logic              stall;

    assign stall     = v_q[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v_q[STAGES-1];
    assign sum       = r_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Each stage adds its own chunk using the carry from the stage before.
    always_comb begin
        a_s[0] = in1;
        b_s[0] = sub ? ~in2 : in2;
        r_s[0] = '0;
        c_s[0] = sub ^ cin;
        v_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_s[k] = a_q[k-1];
            b_s[k] = b_q[k-1];
            r_s[k] = r_q[k-1];
            c_s[k] = c_q[k-1];
            v_s[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_s[k][k*C +: C]}
                    + {1'b0, b_s[k][k*C +: C]}
                    + {{C{1'b0}}, c_s[k]};
            r_n[k] = r_s[k];
            r_n[k][k*C +: C] = part[k][C-1:0];
            c_n[k] = part[k][C];
        end
        ovf_n = (a_s[STAGES-1][WIDTH-1] == b_s[STAGES-1][WIDTH-1])
             && (r_n[STAGES-1][WIDTH-1] != a_s[STAGES-1][WIDTH-1]);
    end

    // Advance all stages together unless the output is blocked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q   <= v_s;
            c_q   <= c_n;
            ovf_q <= ovf_n;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_s[k];
                b_q[k] <= b_s[k];
                r_q[k] <= r_n[k];
            end
        end
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the team's 64-bit combinational adder.
- Splits a WIDTH-bit add/subtract into STAGES equal chunks, one chunk per pipeline stage, with the carry rippling between stage registers.
- Adds a subtract mode, a signed-overflow flag and a valid/ready stream handshake with backpressure.
- Sits in datapaths that need full-width arithmetic at high clock rate and 1 result/cycle throughput.

Parameters:
- WIDTH, 64, operand/result width in bits; must be >= 1.
- STAGES, 4, pipeline depth and chunk count; WIDTH % STAGES must be 0; 1 <= STAGES <= WIDTH. Violation is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: A+B+cin; 1: A-B-cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  raw carry out of MSB
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Effective operand: B' = sub ? ~in2 : in2. Effective carry-in: c0 = sub ? ~cin : cin. Result = A + B' + c0.
  - Add: cout = carry out.
  - Sub: cout = 1 means no borrow, cout = 0 means borrow.
- ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- Chunk width is C = WIDTH/STAGES.
  - Stage k adds bits [k*C +: C] of A and B' with the carry registered from stage k-1 (c0 for k=0).
  - Upper chunks are skew-delayed on entry; lower result chunks are deskew-delayed so all WIDTH bits emerge aligned.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready), combinational from out_ready. The pipeline uses a global stall.
  - While stalled, every stage register, sum, cout and ovf hold their values unchanged.
- Latency is exactly STAGES cycles from accept edge to out_valid high, with no stall. Stalls add one cycle each.
- Throughput is 1 result/cycle with out_ready held high. Results come out in acceptance order; none are dropped or duplicated.
- Bubbles: each stage carries a valid bit. in_valid low inserts a bubble and out_valid is low when it reaches the output. When not stalled, bubbles advance and do not hold up the pipeline.
- Reset: when rst_n = 0 at a rising edge, all stage valid bits clear.
  - Outputs after reset: out_valid = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1.
  - Reset mid-operation flushes all in-flight operations with no output. An input offered in the same cycle as reset is not accepted.
- STAGES = 1: a single registered full-width add with latency 1.
- STAGES = WIDTH: a 1-bit ripple per stage with latency WIDTH.
- No X propagation from unused lanes: bubble stages may hold stale data, but out_valid gates its meaning.

Test Plan:
- Default params, out_ready = 1, sub = 0: FFFFFFFFFFFFFFFF + 0000000000000001, cin = 0 -> after 4 cycles sum = 0000000000000000, cout = 1, ovf = 0. Same operands with cin = 1 -> sum = 0000000000000001, cout = 1.
- Back-to-back stream, one per cycle:
  - (AAAA…AAAA + 5555…5555, cin = 0) -> FFFF…FFFF, cout = 0.
  - (same, cin = 1) -> 0000…0000, cout = 1.
  - (401129BC3F98ACE0 + BA2210AAF48676BC, cin = 1) -> FA333A67341F239D, cout = 0.
  - Results must appear on consecutive cycles 4, 5, 6 in that order.
- Subtract and overflow:
  - 0 - 1 with sub = 1, cin = 0 -> FFFFFFFFFFFFFFFF, cout = 0, ovf = 0.
  - 7FFFFFFFFFFFFFFF + 1 with sub = 0 -> 8000000000000000, ovf = 1.
  - 8000000000000000 - 1 with sub = 1 -> 7FFFFFFFFFFFFFFF, ovf = 1.
- Backpressure:
  - Stimulus: stream 8 random vectors; drop out_ready for 3 cycles while out_valid = 1.
  - Required: in_ready = 0 during the stall; output held stable; all 8 results correct and in order versus a reference model.
- Reset mid-operation: accept 3 operations, assert rst_n = 0 for 1 cycle at cycle 2 -> no out_valid ever rises for them; outputs = 0; in_ready = 1 after reset.
- Parameter sweep: WIDTH/STAGES = 8/1, 16/16 and 32/4 -> 1000 random add/sub operations with random in_valid/out_ready versus the reference model; latency equals STAGES when unstalled.
